// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared scheduler state type and default parameters for the sqrt request scheduler
package sqrt_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} sqrt_sched_state_t;
  localparam int DEF_N       = 16;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the lowest requesting index at or above ptr, wrapping
//   req       - per-requester request bits
//   ptr       - index with highest priority this round
//   grant_idx - chosen requester (0 when nothing requests)
//   any_req   - at least one request present
module rr_arbiter import sqrt_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   grant_idx,
  output logic            any_req
);
  logic [IW-1:0] j;
  // Scan from the far end back to ptr so the nearest index at/after ptr is written last and wins.
  always_comb begin
    grant_idx = '0;
    j = '0;
    any_req = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (req[j]) grant_idx = j;
    end
  end
endmodule

// File: rtl/sqrt_rr_sched.sv
// sqrt_rr_sched: shares one sqrt core among NREQ requesters in round-robin order, with a result timeout
//   clk, reset_n                        - clock, asynchronous active-low reset
//   req_num/req_valid/req_ready         - per-requester operand channels (ready is one-hot or zero)
//   rsp_res/rsp_id/rsp_err/rsp_valid/rsp_ready - shared response channel; err marks a timed-out result
//   core_num/core_num_valid/core_num_ready     - operand issue to the core
//   core_res/core_res_valid/core_res_ready     - result return from the core
//   busy                                - high whenever an operation is in flight
module sqrt_rr_sched import sqrt_pkg::*; #(
  parameter int N       = DEF_N,
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0][N-1:0]   req_num,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  output logic [N/2-1:0]           rsp_res,
  output logic [IW-1:0]            rsp_id,
  output logic                     rsp_err,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [N-1:0]             core_num,
  output logic                     core_num_valid,
  input  logic                     core_num_ready,
  input  logic [N/2-1:0]           core_res,
  input  logic                     core_res_valid,
  output logic                     core_res_ready,
  output logic                     busy
);
  sqrt_sched_state_t state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d, grant_q, grant_d, gnt;
  logic [N-1:0]   op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N/2-1:0] res_q, res_d;
  logic           err_q, err_d, any_req;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant_idx (gnt),
    .any_req   (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (any_req) begin
        grant_d = gnt;
        op_d    = req_num[gnt];
        state_d = S_ISSUE;
      end
      S_ISSUE: if (core_num_ready) begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A result arriving in the timeout cycle is still taken as a good result.
        if (core_res_valid) begin
          res_d   = core_res;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: if (rsp_ready) begin
        ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // The grant is combinational in IDLE, so it is also gated by reset_n to stay low while reset is held.
  assign req_ready      = (state_q == S_IDLE && any_req && reset_n) ? (NREQ'(1) << gnt) : '0;
  assign core_num       = op_q;
  assign core_num_valid = state_q == S_ISSUE;
  assign core_res_ready = state_q == S_WAIT;
  assign rsp_valid      = state_q == S_RESP;
  assign rsp_res        = res_q;
  assign rsp_id         = grant_q;
  assign rsp_err        = err_q;
  assign busy           = state_q != S_IDLE;
endmodule

// File: doc/sqrt_rr_sched.md
SQRT_RR_SCHED -- requirements
Module: sqrt_rr_sched

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the operand width; N shall be even.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters; NREQ shall be at least 2.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of cycles to wait for a core result.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port req_num, input, NREQ x N bits: the operand from each requester.
REQ-007 Port req_valid, input, NREQ bits: per-requester operand valid.
REQ-008 Port req_ready, output, NREQ bits: per-requester accept, at most one bit high at a time.
REQ-009 Port rsp_res, output, N/2 bits: the square-root result.
REQ-010 Port rsp_id, output, $clog2(NREQ) bits: the index of the requester that owns the result.
REQ-011 Port rsp_err, output, 1 bit: set when the result was produced by a timeout.
REQ-012 Port rsp_valid, output, 1 bit, and port rsp_ready, input, 1 bit: the shared response handshake.
REQ-013 Port core_num, output, N bits, with core_num_valid (output) and core_num_ready (input): the operand issue channel to the sqrt core.
REQ-014 Port core_res, input, N/2 bits, with core_res_valid (input) and core_res_ready (output): the result channel from the sqrt core.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE behaviour:
- when any req_valid is high, the grant SHALL go to the lowest index greater than or equal to ptr, with wrap-around;
- req_ready[grant] SHALL be driven high combinationally in that same cycle;
- operand and grant index SHALL be latched, and the FSM SHALL move to ISSUE.
REQ-018 ISSUE behaviour:
- core_num_valid SHALL be 1 and core_num SHALL equal the latched operand;
- both SHALL be held stable until core_num_ready is high;
- the FSM SHALL then move to WAIT and clear the timeout counter.
REQ-019 WAIT behaviour:
- core_res_ready SHALL be 1 and the counter SHALL increment each cycle;
- on core_res_valid: latch core_res, set rsp_err to 0, move to RESP;
- otherwise, when the counter reaches TIMEOUT-1: set rsp_res to 0, set rsp_err to 1, move to RESP.
REQ-020 If core_res_valid and the timeout occur in the same cycle, the valid result SHALL win.
REQ-021 RESP behaviour:
- rsp_valid SHALL be 1, and rsp_res, rsp_id and rsp_err SHALL be held stable until rsp_ready is high;
- on transfer, ptr SHALL become (grant+1) mod NREQ and the FSM SHALL return to IDLE.
REQ-022 No new grant SHALL occur outside IDLE; req_ready SHALL be all-zero in ISSUE, WAIT and RESP.
REQ-023 Minimum request-to-response latency SHALL be 3 cycles, plus the core latency, plus any stall cycles.
REQ-024 A requester that deasserts req_valid before it is granted SHALL NOT be granted.
REQ-025 Requester inputs SHALL be ignored outside IDLE.
REQ-026 A core_res_valid arriving outside WAIT SHALL be ignored.
REQ-027 The pointer SHALL wrap from NREQ-1 to 0.

Reset
REQ-028 Asserting reset_n low SHALL immediately force:
- the FSM to IDLE and ptr to 0;
- the counter, rsp_res, rsp_id, rsp_err, rsp_valid, core_num, core_num_valid, core_res_ready, req_ready and busy to 0.
REQ-029 Reset asserted during any state, including WAIT, SHALL abandon the operation in progress; no response SHALL be produced for it.
REQ-030 The first grant after reset release SHALL follow REQ-017 with ptr = 0.

Structure
REQ-031 The state enum sqrt_sched_state_t SHALL be placed in a shared package, sqrt_pkg.
REQ-032 Default parameter values SHALL be placed in sqrt_pkg.
REQ-033 Round-robin selection SHALL be a separate sub-module, rr_arbiter, with inputs req[NREQ] and ptr, and outputs grant_idx and any_req.
REQ-034 All sequential logic SHALL reside in sqrt_rr_sched.

Verification
REQ-035 Single request: req_valid[2]=1, req_num[2]=144, core returns 12 after 8 cycles -> rsp_res=12, rsp_id=2, rsp_err=0, one rsp_valid transfer.
REQ-036 Contention: after reset, all 4 requesters valid with operands 0, 1, 65535 and 256 -> responses in id order 0, 1, 2, 3 with results 0, 1, 255 and 16.
REQ-037 Backpressure:
- hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready stays 0;
- then rsp_ready=1 -> transfer, and the next grant goes to ptr.
REQ-038 Timeout (TIMEOUT=64): the core never asserts core_res_valid -> exactly 64 WAIT cycles, then rsp_err=1 and rsp_res=0.
REQ-039 Reset mid-operation: reset_n low for 2 cycles during WAIT -> all outputs 0 asynchronously; no response is produced; the next request is granted from ptr=0.
REQ-040 Simultaneous event: core_res_valid in the timeout cycle -> rsp_err=0 and the core value is returned.
